// File: rtl/imm_ext_pkg.sv
// -----------------------------------------------------------------------------
// imm_ext_pkg
// Shared definitions for the immediate-extension stage.
//   SEL_I .. SEL_RAW : 3-bit encodings of the immediate format select (in_sel)
//   imm_sel_t        : convenience type for a format select value
// -----------------------------------------------------------------------------
package imm_ext_pkg;

    typedef logic [2:0] imm_sel_t;

    localparam imm_sel_t SEL_I   = 3'b000; // I-type  inst[31:20]
    localparam imm_sel_t SEL_S   = 3'b001; // S-type  inst[31:25],inst[11:7]
    localparam imm_sel_t SEL_B   = 3'b010; // B-type  branch offset
    localparam imm_sel_t SEL_U   = 3'b011; // U-type  inst[31:12] << 12
    localparam imm_sel_t SEL_J   = 3'b100; // J-type  jump offset
    localparam imm_sel_t SEL_Z   = 3'b101; // CSR zimm inst[19:15]
    localparam imm_sel_t SEL_SH  = 3'b110; // shift amount
    localparam imm_sel_t SEL_RAW = 3'b111; // inst[31:7] unmodified

endpackage

// File: rtl/imm_ext_fmt.sv
// -----------------------------------------------------------------------------
// imm_ext_fmt
// Purely combinational immediate decoder.
// Parameters:
//   XLEN : result width, 32 or 64
// Ports:
//   inst : 32-bit instruction word (bits [6:0] do not contribute)
//   sel  : format select, encodings from imm_ext_pkg
//   imm  : extended immediate, XLEN bits
// -----------------------------------------------------------------------------
module imm_ext_fmt
    import imm_ext_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    input  logic [2:0]      sel,
    output logic [XLEN-1:0] imm
);

    // Every format is built at 64 bits and then truncated, so the
    // sign-extension replications never collapse to zero width when XLEN=32.
    logic [63:0] imm64;
    logic        sign;

    assign sign = inst[31];

    always_comb begin
        imm64 = '0;
        case (sel)
            SEL_I:   imm64 = {{52{sign}}, inst[31:20]};
            SEL_S:   imm64 = {{52{sign}}, inst[31:25], inst[11:7]};
            SEL_B:   imm64 = {{51{sign}}, inst[31], inst[7], inst[30:25],
                              inst[11:8], 1'b0};
            SEL_U:   imm64 = {{32{sign}}, inst[31:12], 12'b0};
            SEL_J:   imm64 = {{43{sign}}, inst[31], inst[19:12], inst[20],
                              inst[30:21], 1'b0};
            SEL_Z:   imm64 = {59'b0, inst[19:15]};
            // RV32 shift amounts are 5 bits; bit 25 is not part of the value.
            SEL_SH:  imm64 = (XLEN == 64) ? {58'b0, inst[25:20]}
                                          : {59'b0, inst[24:20]};
            SEL_RAW: imm64 = {39'b0, inst[31:7]};
            default: imm64 = '0;
        endcase
    end

    // The opcode field never feeds any format.
    logic unused_opcode;
    assign unused_opcode = ^inst[6:0];

    if (XLEN == 64) begin : g_x64
        assign imm = imm64;
    end else begin : g_x32
        logic unused_upper;
        assign unused_upper = ^imm64[63:32];
        assign imm = imm64[31:0];
    end

endmodule

// File: rtl/imm_ext_stage.sv
// -----------------------------------------------------------------------------
// imm_ext_stage
// Pipeline stage that decodes an instruction's immediate on entry and holds
// the result in a two-entry buffer (output register + skid register).
// Build option: define IMM_EXT_ERR_EN to add the sticky `err` output, which
// flags an RV32 shift amount whose bit 25 is set.
// Parameters:
//   XLEN  : datapath width (32 or 64)
//   TAG_W : width of the opaque sideband tag
// Ports:
//   clk, rst (sync, active-high), flush (sync discard of buffered entries)
//   in_valid/in_ready, in_inst, in_sel, in_tag     : upstream side
//   out_valid/out_ready, out_imm, out_sel, out_tag : downstream side
//   err (only with IMM_EXT_ERR_EN)                 : sticky RV32 shamt error
//
// Handshake: a transfer happens on a rising edge where valid && ready. A
// producer holding valid keeps its payload stable until the transfer; this
// stage holds out_* stable while out_valid && !out_ready. in_ready depends
// only on registered state (and the reset input), never on in_valid or
// out_ready, so a full stage refuses input even in a cycle it drains.
// -----------------------------------------------------------------------------
module imm_ext_stage
    import imm_ext_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [2:0]       in_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_sel,
    output logic [TAG_W-1:0] out_tag
`ifdef IMM_EXT_ERR_EN
    ,
    output logic             err
`endif
);

    logic [XLEN-1:0]  dec_imm;

    logic             head_valid;
    logic [XLEN-1:0]  head_imm;
    logic [2:0]       head_sel;
    logic [TAG_W-1:0] head_tag;

    logic             skid_valid;
    logic [XLEN-1:0]  skid_imm;
    logic [2:0]       skid_sel;
    logic [TAG_W-1:0] skid_tag;

    logic             push;
    logic             pop;

    imm_ext_fmt #(
        .XLEN (XLEN)
    ) u_fmt (
        .inst (in_inst),
        .sel  (in_sel),
        .imm  (dec_imm)
    );

    // The skid entry is only ever occupied behind a valid head, so the
    // stage is full exactly when the skid entry is valid.
    assign in_ready  = !rst && !skid_valid;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = head_valid && out_ready;

    assign out_valid = head_valid;
    assign out_imm   = head_imm;
    assign out_sel   = head_sel;
    assign out_tag   = head_tag;

    always_ff @(posedge clk) begin
        if (rst) begin
            head_valid <= 1'b0;
            head_imm   <= '0;
            head_sel   <= '0;
            head_tag   <= '0;
            skid_valid <= 1'b0;
            skid_imm   <= '0;
            skid_sel   <= '0;
            skid_tag   <= '0;
        end else if (flush) begin
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (pop) begin
            if (skid_valid) begin
                // Promote the older buffered entry; push is impossible here.
                head_imm   <= skid_imm;
                head_sel   <= skid_sel;
                head_tag   <= skid_tag;
                skid_valid <= 1'b0;
            end else if (push) begin
                head_imm   <= dec_imm;
                head_sel   <= in_sel;
                head_tag   <= in_tag;
            end else begin
                head_valid <= 1'b0;
            end
        end else if (push) begin
            if (!head_valid) begin
                head_valid <= 1'b1;
                head_imm   <= dec_imm;
                head_sel   <= in_sel;
                head_tag   <= in_tag;
            end else begin
                skid_valid <= 1'b1;
                skid_imm   <= dec_imm;
                skid_sel   <= in_sel;
                skid_tag   <= in_tag;
            end
        end
    end

`ifdef IMM_EXT_ERR_EN
    localparam bit IS_RV32 = (XLEN == 32);

    // Sticky until reset; flush does not clear it, and an entry dropped by
    // flush was never accepted so it cannot set it.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (IS_RV32 && push && (in_sel == SEL_SH) && in_inst[25]) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_imm_ext_stage.sv
// -----------------------------------------------------------------------------
// tb_imm_ext_stage
// Directed testbench for imm_ext_stage. Inputs are driven and outputs sampled
// on the falling clock edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_imm_ext_stage;
    import imm_ext_pkg::*;

    localparam int XLEN  = 32;
    localparam int TAG_W = 4;
    localparam int SB_W  = 64 + TAG_W;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_inst;
    logic [2:0]       in_sel;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_sel;
    logic [TAG_W-1:0] out_tag;
`ifdef IMM_EXT_ERR_EN
    logic             err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard: {expected imm (64b, zero-extended), expected tag}
    logic [SB_W-1:0] exp_q[$];

    imm_ext_stage #(
        .XLEN  (XLEN),
        .TAG_W (TAG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inst   (in_inst),
        .in_sel    (in_sel),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_sel   (out_sel),
        .out_tag   (out_tag)
`ifdef IMM_EXT_ERR_EN
        ,
        .err       (err)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check_eq(input string name, input logic [63:0] got,
                            input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    // Selects the hand-computed expectation for the configured XLEN.
    function automatic logic [63:0] xv(input logic [63:0] v32,
                                       input logic [63:0] v64);
        return (XLEN == 64) ? v64 : v32;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_in(input logic [31:0] inst, input logic [2:0] sel,
                            input logic [TAG_W-1:0] tag);
        in_valid = 1'b1;
        in_inst  = inst;
        in_sel   = sel;
        in_tag   = tag;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_inst  = '0;
        in_sel   = '0;
        in_tag   = '0;
    endtask

    task automatic expect_push(input logic [63:0] imm, input logic [TAG_W-1:0] tag);
        exp_q.push_back({imm, tag});
    endtask

    // Compares the current head against the oldest expected entry.
    task automatic check_head(input string name);
        logic [SB_W-1:0] e;
        check_eq({name, "_valid"}, 64'(out_valid), 64'd1);
        check_eq({name, "_sb_nonempty"}, 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq({name, "_imm"}, 64'(out_imm), e[SB_W-1:TAG_W]);
            check_eq({name, "_tag"}, 64'(out_tag), 64'(e[TAG_W-1:0]));
        end
    endtask

    // One entry through an idle stage with out_ready high.
    task automatic send_one(input string name, input logic [31:0] inst,
                            input logic [2:0] sel, input logic [TAG_W-1:0] tag,
                            input logic [63:0] exp_imm);
        out_ready = 1'b1;
        drive_in(inst, sel, tag);
        check_eq({name, "_in_ready"}, 64'(in_ready), 64'd1);
        expect_push(exp_imm, tag);
        step();
        idle_in();
        check_eq({name, "_sel"}, 64'(out_sel), 64'(sel));
        check_head(name);
        step();
        check_eq({name, "_drained"}, 64'(out_valid), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        idle_in();

        // Reset behaviour
        repeat (3) step();
        check_eq("rst_in_ready_low", 64'(in_ready), 64'd0);
        rst = 1'b0;
        step();
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_out_imm", 64'(out_imm), 64'd0);
        check_eq("rst_out_sel", 64'(out_sel), 64'd0);
        check_eq("rst_out_tag", 64'(out_tag), 64'd0);
`ifdef IMM_EXT_ERR_EN
        check_eq("rst_err", 64'(err), 64'd0);
`endif

        // Format decode, hand-computed
        send_one("i_neg1", 32'hFFF00093, SEL_I, 4'd1,
                 xv(64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF));
        send_one("s_neg4", 32'hFE112E23, SEL_S, 4'd2,
                 xv(64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC));
        send_one("u_pos", 32'h123452B7, SEL_U, 4'd3, 64'h1234_5000);
        send_one("u_neg", 32'h800000B7, SEL_U, 4'd4,
                 xv(64'h8000_0000, 64'hFFFF_FFFF_8000_0000));
        send_one("b_pos8", 32'h00000463, SEL_B, 4'd5, 64'h8);
        send_one("b_neg4", 32'hFE000EE3, SEL_B, 4'd6,
                 xv(64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC));
        send_one("j_pos8", 32'h0080006F, SEL_J, 4'd7, 64'h8);
        send_one("j_neg4", 32'hFFDFF06F, SEL_J, 4'd8,
                 xv(64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC));
        send_one("z_31", 32'h000FD073, SEL_Z, 4'd9, 64'h1F);
        send_one("sh_5", 32'h00509093, SEL_SH, 4'd10, 64'h5);
        send_one("raw_ones", 32'hFFFFFFFF, SEL_RAW, 4'd11, 64'h1FF_FFFF);
`ifdef IMM_EXT_ERR_EN
        check_eq("err_clear_before_sh", 64'(err), 64'd0);
`endif
        send_one("sh_bit25", 32'h02009093, SEL_SH, 4'd12, xv(64'h0, 64'h20));
`ifdef IMM_EXT_ERR_EN
        check_eq("err_after_sh", 64'(err), xv(64'd1, 64'd0));
        send_one("err_sticky_i", 32'h00100093, SEL_I, 4'd13, 64'h1);
        check_eq("err_sticky", 64'(err), xv(64'd1, 64'd0));
`endif

        // Back-to-back stream: one entry per cycle with out_ready high
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_in({12'(i * 3 + 1), 20'h00013}, SEL_I, 4'(i));
            check_eq("stream_in_ready", 64'(in_ready), 64'd1);
            expect_push(64'(i * 3 + 1), 4'(i));
            step();
            check_head("stream");
        end
        idle_in();
        step();
        check_eq("stream_drained", 64'(out_valid), 64'd0);

        // Stall: tags 1,2,3 offered for 4 cycles, only 1 and 2 fit
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            int t;
            t = (k < 3) ? k + 1 : 3;
            drive_in({12'(t * 16), 20'h00013}, SEL_I, 4'(t));
            check_eq("stall_in_ready", 64'(in_ready), (k < 2) ? 64'd1 : 64'd0);
            if (k < 2) expect_push(64'(t * 16), 4'(t));
            step();
            check_eq("stall_hold_valid", 64'(out_valid), 64'd1);
            check_eq("stall_hold_tag", 64'(out_tag), 64'd1);
            check_eq("stall_hold_imm", 64'(out_imm), 64'd16);
        end
        idle_in();
        out_ready = 1'b1;
        check_head("stall_t1");
        step();
        check_head("stall_t2");
        step();
        check_eq("stall_drained", 64'(out_valid), 64'd0);
        check_eq("stall_sb_empty", 64'(exp_q.size()), 64'd0);

        // Flush with both entries held and a new entry offered
        out_ready = 1'b0;
        drive_in(32'h00100093, SEL_I, 4'd1);
        step();
        drive_in(32'h00200093, SEL_I, 4'd2);
        step();
        check_eq("flush_full_in_ready", 64'(in_ready), 64'd0);
        drive_in(32'h00900093, SEL_I, 4'd9);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle_in();
        check_eq("flush_full_out_valid", 64'(out_valid), 64'd0);
        check_eq("flush_full_in_ready_after", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (2) begin
            step();
            check_eq("flush_full_no_ghost", 64'(out_valid), 64'd0);
        end

        // Flush beats an input transfer into an empty stage
        out_ready = 1'b0;
        drive_in(32'h00A00093, SEL_I, 4'd10);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle_in();
        check_eq("flush_drop_out_valid", 64'(out_valid), 64'd0);
        step();
        check_eq("flush_drop_still_empty", 64'(out_valid), 64'd0);

        // Reset mid-stall with both entries held
        out_ready = 1'b0;
        drive_in(32'h02009093, SEL_SH, 4'd4);
        step();
        drive_in(32'h00500093, SEL_I, 4'd5);
        step();
        check_eq("rst_stall_full", 64'(in_ready), 64'd0);
        drive_in(32'h00600093, SEL_I, 4'd6);
        rst = 1'b1;
        step();
        check_eq("rst_stall_in_ready_low", 64'(in_ready), 64'd0);
        step();
        rst = 1'b0;
        idle_in();
        step();
        check_eq("rst_stall_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_stall_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_stall_out_tag", 64'(out_tag), 64'd0);
        check_eq("rst_stall_out_imm", 64'(out_imm), 64'd0);
`ifdef IMM_EXT_ERR_EN
        check_eq("rst_stall_err", 64'(err), 64'd0);
`endif

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imm_ext_stage.md
IMM_EXT_STAGE -- requirements
Module: imm_ext_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 or 64 are legal.
REQ-002 SHALL have parameter TAG_W, default 4, width of the sideband tag carried with each instruction.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port flush, input, 1, synchronous discard of all buffered entries.
REQ-006 SHALL have port in_valid, input, 1, upstream entry valid.
REQ-007 SHALL have port in_ready, output, 1, stage can accept an entry this cycle.
REQ-008 SHALL have port in_inst, input, 32, instruction word; bits [6:0] are ignored.
REQ-009 SHALL have port in_sel, input, 3, immediate format select.
REQ-010 SHALL have port in_tag, input, TAG_W, opaque sideband, passed through unchanged.
REQ-011 SHALL have port out_valid, output, 1, output entry valid.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts.
REQ-013 SHALL have port out_imm, output, XLEN, extended immediate.
REQ-014 SHALL have port out_sel, output, 3, in_sel echoed.
REQ-015 SHALL have port out_tag, output, TAG_W, in_tag echoed.

Function
REQ-016 SHALL decode in_sel as: 000 I {inst[31:20]}; 001 S {inst[31:25],inst[11:7]}; 010 B {inst[31],inst[7],inst[30:25],inst[11:8],0}; 011 U {inst[31:12],12'b0}; 100 J {inst[31],inst[19:12],inst[20],inst[30:21],0}.
REQ-017 SHALL sign-extend I/S/B/J from inst[31] to XLEN, and sign-extend the 32-bit U result to XLEN when XLEN=64.
REQ-018 SHALL decode 101 Z as inst[19:15] zero-extended (CSR zimm).
REQ-019 SHALL decode 110 SH as zero-extended inst[24:20] when XLEN=32 and inst[25:20] when XLEN=64.
REQ-020 SHALL decode 111 RAW as inst[31:7] zero-extended to XLEN.
REQ-021 SHALL perform decode at the input, storing the result, never the raw instruction.
REQ-022 SHALL buffer up to 2 entries (output register plus skid register), FIFO order.
REQ-023 SHALL transfer on the input side iff in_valid && in_ready, and on the output side iff out_valid && out_ready.
REQ-024 SHALL present an entry accepted in cycle N at the outputs no earlier than cycle N+1 (latency 1 when unstalled).
REQ-025 SHALL drive in_ready from registered state only: high iff fewer than 2 entries are held.
REQ-026 SHALL sustain 1 entry per cycle when out_ready is continuously high.
REQ-027 SHALL hold out_imm/out_sel/out_tag stable while out_valid && !out_ready.
REQ-028 SHALL, with 2 entries held, a simultaneous output transfer and in_valid, accept nothing that cycle (in_ready already low).
REQ-029 SHALL, on flush, empty both entries next cycle; flush has priority over a same-cycle input transfer, which is dropped.

Reset
REQ-030 SHALL, while rst is high, force in_ready=0 and clear both entries; rst has priority over flush and all handshakes.
REQ-031 SHALL, in the first cycle after rst falls, show out_valid=0 and in_ready=1; out_imm, out_sel and out_tag reset to 0.

Configuration
REQ-032 SHALL, with IMM_EXT_ERR_EN defined, add output err (1 bit), sticky: set when an SH entry with inst[25]=1 is accepted while XLEN=32; cleared only by rst.
REQ-033 SHALL, without IMM_EXT_ERR_EN, omit the err port; decode is unchanged.

Structure
REQ-034 SHALL place the in_sel encoding constants (SEL_I..SEL_RAW) in shared package imm_ext_pkg.
REQ-035 SHALL implement decode in one combinational sub-module imm_ext_fmt, parameterised by XLEN, instantiated once.

Verification
REQ-036 SHALL check: XLEN=32, inst 0xFFF00093 with sel I -> out_imm 0xFFFFFFFF one cycle later; XLEN=64 -> 0xFFFFFFFFFFFFFFFF.
REQ-037 SHALL check: inst 0xFE112E23 with sel S -> 0xFFFFFFFC; inst 0x123452B7 with sel U -> 0x12345000.
REQ-038 SHALL check: out_ready=0 and in_valid=1 for 4 cycles with tags 1,2,3 -> only tags 1 and 2 accepted, in_ready=0; release -> tags 1 then 2 on consecutive cycles, with values held while stalled.
REQ-039 SHALL check: 2 entries held, flush=1 together with in_valid=1 -> out_valid=0 next cycle and the new entry never appears.
REQ-040 SHALL check: inst 0x02009093 with sel SH -> XLEN=32: out_imm 0, err=1 (macro defined); XLEN=64: out_imm 0x20, err=0.
REQ-041 SHALL check: rst asserted mid-stall with 2 entries held -> the first cycle after release shows out_valid=0, in_ready=1 and err=0.
